// File: rtl/load_pkg.sv
// Shared encodings, FSM state type and funct3 size decode for the load alignment unit.
package load_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ0,
        ST_WAIT0,
        ST_REQ1,
        ST_WAIT1,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic [3:0] bytes;
        logic       sext;
    } load_size_t;

    // Access width in bytes and sign-extension flag; 111 decodes as 8 bytes and is rejected elsewhere.
    function automatic load_size_t size_decode(input logic [2:0] funct3);
        load_size_t s;
        s.sext = ~funct3[2];
        case (funct3)
            F3_LB, F3_LBU: s.bytes = 4'd1;
            F3_LH, F3_LHU: s.bytes = 4'd2;
            F3_LW, F3_LWU: s.bytes = 4'd4;
            default:       s.bytes = 4'd8;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Right-shifts the merged beats by the byte offset and sign/zero-extends the loaded field to XLEN.
module load_extend
    import load_pkg::*;
#(
    parameter  int unsigned XLEN = 64,
    localparam int unsigned OFFW = $clog2(XLEN / 8)
) (
    input  logic [2*XLEN-1:0] merged,
    input  logic [OFFW-1:0]   off,
    input  logic [2:0]        funct3,
    output logic [XLEN-1:0]   result
);

    localparam int unsigned IDXW = $clog2(XLEN);

    load_size_t      sz;
    logic [XLEN-1:0] lower;
    logic [XLEN-1:0] keep;
    int unsigned     nbits;
    logic [IDXW-1:0] msb_idx;
    logic            fill;

    always_comb begin
        sz      = size_decode(funct3);
        lower   = XLEN'(merged >> {off, 3'b000});
        nbits   = 8 * 32'(sz.bytes);
        if (nbits > XLEN) begin
            nbits = XLEN;
        end
        msb_idx = IDXW'(nbits - 1);
        fill    = sz.sext & lower[msb_idx];
        keep    = (nbits >= XLEN) ? '1 : ((XLEN'(1) << nbits) - XLEN'(1));
        result  = (lower & keep) | ({XLEN{fill}} & ~keep);
    end

endmodule

// File: rtl/load_align_unit.sv
// Load datapath: one request at a time, one or two aligned bus reads, merge/extend, held writeback.
module load_align_unit
    import load_pkg::*;
#(
    parameter int unsigned XLEN             = 64,
    parameter bit          ALLOW_MISALIGNED = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [4:0]      req_rd,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      wb_rd,
    output logic            wb_fault
);

    localparam int unsigned NBYTES = XLEN / 8;
    localparam int unsigned OFFW   = $clog2(NBYTES);

    state_t            state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic [OFFW-1:0]   off_q, off_d;
    logic [XLEN-1:0]   base_q, base_d;
    logic              cross_q, cross_d;
    logic [XLEN-1:0]   beat0_q, beat0_d;
    logic [XLEN-1:0]   mem_addr_d;
    logic [XLEN-1:0]   wb_data_d;
    logic [4:0]        wb_rd_d;
    logic              wb_fault_d;

    load_size_t        req_size;
    logic [OFFW-1:0]   req_off;
    logic [XLEN-1:0]   req_base;
    logic              req_cross;
    logic              req_illegal;
    logic [2*XLEN-1:0] merged;
    logic [XLEN-1:0]   ext_data;

    // Incoming request decode: offset, aligned base, crossing and legality.
    always_comb begin
        req_size    = size_decode(req_funct3);
        req_off     = req_addr[OFFW-1:0];
        req_base    = {req_addr[XLEN-1:OFFW], OFFW'(0)};
        req_cross   = (32'(req_off) + 32'(req_size.bytes)) > NBYTES;
        req_illegal = (req_funct3 == 3'b111) ||
                      ((XLEN == 32) && ((req_funct3 == F3_LD) || (req_funct3 == F3_LWU)));
    end

    // The beat arriving this cycle is merged directly so the result is registered on entry to RESP.
    assign merged = (state_q == ST_WAIT1) ? {mem_rsp_data, beat0_q} : {XLEN'(0), mem_rsp_data};

    load_extend #(.XLEN(XLEN)) u_extend (
        .merged (merged),
        .off    (off_q),
        .funct3 (f3_q),
        .result (ext_data)
    );

    always_comb begin
        state_d    = state_q;
        f3_d       = f3_q;
        off_d      = off_q;
        base_d     = base_q;
        cross_d    = cross_q;
        beat0_d    = beat0_q;
        mem_addr_d = mem_addr;
        wb_data_d  = wb_data;
        wb_rd_d    = wb_rd;
        wb_fault_d = wb_fault;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    f3_d    = req_funct3;
                    off_d   = req_off;
                    base_d  = req_base;
                    cross_d = req_cross;
                    wb_rd_d = req_rd;
                    if (req_illegal || (req_cross && !ALLOW_MISALIGNED)) begin
                        state_d    = ST_RESP;
                        wb_data_d  = '0;
                        wb_fault_d = 1'b1;
                    end else begin
                        state_d    = ST_REQ0;
                        mem_addr_d = req_base;
                    end
                end
            end
            ST_REQ0: begin
                if (mem_req_ready) state_d = ST_WAIT0;
            end
            ST_WAIT0: begin
                if (mem_rsp_valid) begin
                    beat0_d = mem_rsp_data;
                    if (cross_q) begin
                        state_d    = ST_REQ1;
                        mem_addr_d = base_q + XLEN'(NBYTES);
                    end else begin
                        state_d    = ST_RESP;
                        wb_data_d  = ext_data;
                        wb_fault_d = 1'b0;
                    end
                end
            end
            ST_REQ1: begin
                if (mem_req_ready) state_d = ST_WAIT1;
            end
            ST_WAIT1: begin
                if (mem_rsp_valid) begin
                    state_d    = ST_RESP;
                    wb_data_d  = ext_data;
                    wb_fault_d = 1'b0;
                end
            end
            ST_RESP: begin
                if (wb_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they align with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            f3_q          <= '0;
            off_q         <= '0;
            base_q        <= '0;
            cross_q       <= 1'b0;
            beat0_q       <= '0;
            req_ready     <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            wb_valid      <= 1'b0;
            wb_data       <= '0;
            wb_rd         <= '0;
            wb_fault      <= 1'b0;
        end else begin
            state_q       <= state_d;
            f3_q          <= f3_d;
            off_q         <= off_d;
            base_q        <= base_d;
            cross_q       <= cross_d;
            beat0_q       <= beat0_d;
            req_ready     <= (state_d == ST_IDLE);
            mem_req_valid <= (state_d == ST_REQ0) || (state_d == ST_REQ1);
            mem_addr      <= mem_addr_d;
            wb_valid      <= (state_d == ST_RESP);
            wb_data       <= wb_data_d;
            wb_rd         <= wb_rd_d;
            wb_fault      <= wb_fault_d;
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: XLEN=64 split/no-split variants and an XLEN=32 variant.
module tb_load_align_unit;
    import load_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  sel;
    logic        req_valid;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [4:0]  req_rd;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_data;
    logic        wb_ready;

    logic [2:0]  o_req_ready, o_mem_req_valid, o_wb_valid, o_wb_fault;
    logic [63:0] a_mem_addr, a_wb_data, b_mem_addr, b_wb_data;
    logic [31:0] c_mem_addr, c_wb_data;
    logic [4:0]  a_wb_rd, b_wb_rd, c_wb_rd;

    logic        req_ready, mem_req_valid, wb_valid, wb_fault;
    logic [63:0] mem_addr, wb_data;
    logic [4:0]  wb_rd;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [63:0] B0 = 64'h8877665544332211;
    localparam logic [63:0] B1 = 64'h00000000CCBBAA99;

    always #5 clk = ~clk;

    load_align_unit #(.XLEN(64), .ALLOW_MISALIGNED(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid && sel == 2'd0), .req_ready(o_req_ready[0]),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_rd(req_rd),
        .mem_req_valid(o_mem_req_valid[0]), .mem_req_ready(1'b1), .mem_addr(a_mem_addr),
        .mem_rsp_valid(mem_rsp_valid && sel == 2'd0), .mem_rsp_data(mem_rsp_data),
        .wb_valid(o_wb_valid[0]), .wb_ready(wb_ready && sel == 2'd0),
        .wb_data(a_wb_data), .wb_rd(a_wb_rd), .wb_fault(o_wb_fault[0])
    );

    load_align_unit #(.XLEN(64), .ALLOW_MISALIGNED(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid && sel == 2'd1), .req_ready(o_req_ready[1]),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_rd(req_rd),
        .mem_req_valid(o_mem_req_valid[1]), .mem_req_ready(1'b1), .mem_addr(b_mem_addr),
        .mem_rsp_valid(mem_rsp_valid && sel == 2'd1), .mem_rsp_data(mem_rsp_data),
        .wb_valid(o_wb_valid[1]), .wb_ready(wb_ready && sel == 2'd1),
        .wb_data(b_wb_data), .wb_rd(b_wb_rd), .wb_fault(o_wb_fault[1])
    );

    load_align_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid && sel == 2'd2), .req_ready(o_req_ready[2]),
        .req_funct3(req_funct3), .req_addr(req_addr[31:0]), .req_rd(req_rd),
        .mem_req_valid(o_mem_req_valid[2]), .mem_req_ready(1'b1), .mem_addr(c_mem_addr),
        .mem_rsp_valid(mem_rsp_valid && sel == 2'd2), .mem_rsp_data(mem_rsp_data[31:0]),
        .wb_valid(o_wb_valid[2]), .wb_ready(wb_ready && sel == 2'd2),
        .wb_data(c_wb_data), .wb_rd(c_wb_rd), .wb_fault(o_wb_fault[2])
    );

    // Observe the instance currently under test.
    always_comb begin
        req_ready     = o_req_ready[sel];
        mem_req_valid = o_mem_req_valid[sel];
        wb_valid      = o_wb_valid[sel];
        wb_fault      = o_wb_fault[sel];
        case (sel)
            2'd0:    begin mem_addr = a_mem_addr; wb_data = a_wb_data; wb_rd = a_wb_rd; end
            2'd1:    begin mem_addr = b_mem_addr; wb_data = b_wb_data; wb_rd = b_wb_rd; end
            default: begin mem_addr = 64'(c_mem_addr); wb_data = 64'(c_wb_data); wb_rd = c_wb_rd; end
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        check(tag, 64'(obs), 64'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk1({tag, " req_ready"}, req_ready, 1'b1);
        chk1({tag, " mem_req_valid"}, mem_req_valid, 1'b0);
        check({tag, " mem_addr"}, mem_addr, 64'd0);
        chk1({tag, " wb_valid"}, wb_valid, 1'b0);
        check({tag, " wb_data"}, wb_data, 64'd0);
        check({tag, " wb_rd"}, 64'(wb_rd), 64'd0);
        chk1({tag, " wb_fault"}, wb_fault, 1'b0);
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [4:0] rd, input logic [63:0] b0, input logic [63:0] b1,
                           input bit two, input logic [63:0] exp_addr,
                           input logic [63:0] exp_data, input int hold);
        logic [63:0] step;
        step = (sel == 2'd2) ? 64'd4 : 64'd8;
        chk1({tag, " ready"}, req_ready, 1'b1);
        req_valid = 1'b1; req_funct3 = f3; req_addr = addr; req_rd = rd;
        tick();
        req_valid = 1'b0;
        chk1({tag, " mreq0"}, mem_req_valid, 1'b1);
        check({tag, " addr0"}, mem_addr, exp_addr);
        chk1({tag, " busy"}, req_ready, 1'b0);
        tick();
        chk1({tag, " wait0"}, mem_req_valid, 1'b0);
        mem_rsp_valid = 1'b1; mem_rsp_data = b0;
        tick();
        mem_rsp_valid = 1'b0;
        if (two) begin
            chk1({tag, " mreq1"}, mem_req_valid, 1'b1);
            check({tag, " addr1"}, mem_addr, exp_addr + step);
            tick();
            mem_rsp_valid = 1'b1; mem_rsp_data = b1;
            tick();
            mem_rsp_valid = 1'b0;
        end
        chk1({tag, " wb_valid"}, wb_valid, 1'b1);
        check({tag, " wb_data"}, wb_data, exp_data);
        check({tag, " wb_rd"}, 64'(wb_rd), 64'(rd));
        chk1({tag, " wb_fault"}, wb_fault, 1'b0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk1({tag, " hold_valid"}, wb_valid, 1'b1);
            check({tag, " hold_data"}, wb_data, exp_data);
            chk1({tag, " hold_busy"}, req_ready, 1'b0);
        end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk1({tag, " done"}, wb_valid, 1'b0);
        chk1({tag, " idle"}, req_ready, 1'b1);
    endtask

    task automatic do_fault(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                            input logic [4:0] rd);
        req_valid = 1'b1; req_funct3 = f3; req_addr = addr; req_rd = rd;
        tick();
        req_valid = 1'b0;
        chk1({tag, " no_mreq"}, mem_req_valid, 1'b0);
        chk1({tag, " wb_valid"}, wb_valid, 1'b1);
        chk1({tag, " wb_fault"}, wb_fault, 1'b1);
        check({tag, " wb_data"}, wb_data, 64'd0);
        check({tag, " wb_rd"}, 64'(wb_rd), 64'(rd));
        chk1({tag, " busy"}, req_ready, 1'b0);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk1({tag, " done"}, wb_valid, 1'b0);
        chk1({tag, " idle"}, req_ready, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; sel = 2'd0;
        req_valid = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_rd = '0;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0; wb_ready = 1'b0;
        tick();
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            check_reset("reset");
        end
        rst_n = 1'b1;
        sel = 2'd0;
        tick();

        do_load("lb_1003",  F3_LB,  64'h1003, 5'd5,  B0, 64'd0, 1'b0, 64'h1000, 64'h0000000000000044, 0);
        do_load("lh_1006",  F3_LH,  64'h1006, 5'd6,  B0, 64'd0, 1'b0, 64'h1000, 64'hFFFFFFFFFFFF8877, 0);
        do_load("lhu_1006", F3_LHU, 64'h1006, 5'd7,  B0, 64'd0, 1'b0, 64'h1000, 64'h0000000000008877, 0);
        do_load("lw_cross", F3_LW,  64'h1006, 5'd8,  B0, B1,    1'b1, 64'h1000, 64'hFFFFFFFFAA998877, 0);
        do_load("ld_1000",  F3_LD,  64'h1000, 5'd1,  B0, 64'd0, 1'b0, 64'h1000, 64'h8877665544332211, 0);
        do_load("lwu_1004", F3_LWU, 64'h1004, 5'd2,  B0, 64'd0, 1'b0, 64'h1000, 64'h0000000088776655, 0);
        do_load("lb_1007",  F3_LB,  64'h1007, 5'd3,  B0, 64'd0, 1'b0, 64'h1000, 64'hFFFFFFFFFFFFFF88, 0);
        do_load("lbu_1007", F3_LBU, 64'h1007, 5'd4,  B0, 64'd0, 1'b0, 64'h1000, 64'h0000000000000088, 0);
        do_load("ld_wrap",  F3_LD,  64'hFFFFFFFFFFFFFFFC, 5'd31, B0, B1, 1'b1,
                64'hFFFFFFFFFFFFFFF8, 64'hCCBBAA9988776655, 0);
        do_load("lh_hold",  F3_LH,  64'h1006, 5'd6,  B0, 64'd0, 1'b0, 64'h1000, 64'hFFFFFFFFFFFF8877, 5);
        do_fault("f3_111", 3'b111, 64'h1006, 5'd3);

        // Reset while waiting for the first beat.
        req_valid = 1'b1; req_funct3 = F3_LB; req_addr = 64'h1003; req_rd = 5'd9;
        tick();
        req_valid = 1'b0;
        tick();
        #1 rst_n = 1'b0;
        #1 check_reset("rst_wait0");
        tick();
        rst_n = 1'b1;
        tick();
        do_load("post_rst", F3_LB, 64'h1003, 5'd5, B0, 64'd0, 1'b0, 64'h1000, 64'h0000000000000044, 0);

        sel = 2'd1;
        #1;
        do_fault("nomis_lw_cross", F3_LW, 64'h1006, 5'd10);
        do_load("nomis_lw_1004", F3_LW, 64'h1004, 5'd11, B0, 64'd0, 1'b0, 64'h1000, 64'hFFFFFFFF88776655, 0);

        sel = 2'd2;
        #1;
        do_fault("x32_lwu", F3_LWU, 64'h2000, 5'd12);
        do_fault("x32_ld",  F3_LD,  64'h2000, 5'd13);
        do_load("x32_lw", F3_LW, 64'h2000, 5'd14, 64'h80000001, 64'd0, 1'b0, 64'h2000,
                64'h0000000080000001, 0);
        do_load("x32_lh_cross", F3_LH, 64'h2003, 5'd15, 64'h44332211, 64'h000000AA, 1'b1, 64'h2000,
                64'h00000000FFFFAA44, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
